// File: rtl/uart_axis_pkg.sv
// Shared types and constants for the UART receive / AXI-Stream packing path.
package uart_axis_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   localparam int unsigned AXIS_DATA_W = 32;
   localparam int unsigned AXIS_BYTES  = 4;
   localparam int unsigned CNT_W       = $clog2(AXIS_BYTES + 1);

   // Contiguous lane mask with the low n lanes set.
   function automatic logic [AXIS_BYTES-1:0] keep_mask(input logic [CNT_W-1:0] n);
      logic [AXIS_BYTES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < AXIS_BYTES; i++) begin
         if (i < 32'(n)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/uart_rx_bit.sv
// 8N1 bit-level receiver: input synchroniser, mid-bit sampling FSM and byte strobe.
module uart_rx_bit
   import uart_axis_pkg::*;
#(
   parameter int unsigned CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       line_idle
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

   logic          rx_meta;
   logic          rxs;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   assign line_idle = (state == ST_IDLE) || (state == ST_WAIT_HIGH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta    <= 1'b1;
         rxs        <= 1'b1;
         state      <= ST_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rxs        <= rx_meta;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state <= ST_START;
                  cnt   <= HALF_LOAD;
               end
            end
            ST_START: begin
               if (cnt == '0) begin
                  if (!rxs) begin
                     state   <= ST_DATA;
                     cnt     <= FULL_LOAD;
                     bit_idx <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DATA: begin
               if (cnt == '0) begin
                  shift <= {rxs, shift[7:1]};
                  cnt   <= FULL_LOAD;
                  if (bit_idx == 3'd7) state <= ST_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_STOP: begin
               if (cnt == '0) begin
                  if (rxs) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shift;
                     state      <= ST_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            // A held-low line (break) must return high before a new start is accepted.
            ST_WAIT_HIGH: begin
               if (rxs) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_axis_master.sv
// UART receiver packing bytes little-endian into 32-bit AXI-Stream beats,
// closing each packet with TLAST after a line-idle timeout.
module uart_rx_axis_master
   import uart_axis_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 434,
   parameter int unsigned IDLE_TIMEOUT = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic [AXIS_DATA_W-1:0] M_AXIS_TDATA,
   output logic [AXIS_BYTES-1:0]  M_AXIS_TKEEP,
   output logic                   M_AXIS_TLAST,
   output logic                   frame_err,
   output logic                   overrun_err
);

   localparam int unsigned LIMIT = IDLE_TIMEOUT * CLK_DIV;
   localparam int unsigned TW    = $clog2(LIMIT + 1);
   localparam logic [TW-1:0] TLIM = TW'(LIMIT);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(AXIS_BYTES);

   logic                   byte_valid;
   logic [7:0]             byte_data;
   logic                   line_idle;
   logic [TW-1:0]          tcnt;
   logic [AXIS_DATA_W-1:0] pack_data;
   logic [CNT_W-1:0]       count;
   logic                   flush_pend;
   logic                   out_free;

   uart_rx_bit #(
      .CLK_DIV (CLK_DIV)
   ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err),
      .line_idle  (line_idle)
   );

   assign out_free = !M_AXIS_TVALID || M_AXIS_TREADY;

   // Idle timer: cleared while a character is on the line, saturates at the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
      end else if (!line_idle) begin
         tcnt <= '0;
      end else if (tcnt != TLIM) begin
         tcnt <= tcnt + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pack_data     <= '0;
         count         <= '0;
         flush_pend    <= 1'b0;
         overrun_err   <= 1'b0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TKEEP  <= '0;
         M_AXIS_TLAST  <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;

         if (!flush_pend && (tcnt == TLIM) && (count != '0)) flush_pend <= 1'b1;

         // A pending flush is always emitted before any newly arrived byte is packed.
         if (flush_pend) begin
            if (out_free) begin
               M_AXIS_TVALID <= 1'b1;
               M_AXIS_TDATA  <= pack_data;
               M_AXIS_TKEEP  <= keep_mask(count);
               M_AXIS_TLAST  <= 1'b1;
               flush_pend    <= 1'b0;
               if (byte_valid) begin
                  pack_data <= AXIS_DATA_W'(byte_data);
                  count     <= CNT_W'(1);
               end else begin
                  pack_data <= '0;
                  count     <= '0;
               end
            end else if (byte_valid) begin
               overrun_err <= 1'b1;
            end
         end else if (byte_valid) begin
            if (count == FULL_CNT) begin
               if (out_free) begin
                  M_AXIS_TVALID <= 1'b1;
                  M_AXIS_TDATA  <= pack_data;
                  M_AXIS_TKEEP  <= '1;
                  M_AXIS_TLAST  <= 1'b0;
                  pack_data     <= AXIS_DATA_W'(byte_data);
                  count         <= CNT_W'(1);
               end else begin
                  overrun_err <= 1'b1;
               end
            end else begin
               pack_data[{count[1:0], 3'b000} +: 8] <= byte_data;
               count <= count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_axis_master.sv
// Self-checking bench for uart_rx_axis_master with a chunk-of-four packet model.
module tb_uart_rx_axis_master;

   localparam int unsigned CLK_DIV      = 8;
   localparam int unsigned IDLE_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tlast;
   logic        frame_err;
   logic        overrun_err;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;
   typedef beat_t      beat_q_t[$];
   typedef logic [7:0] byte_q_t[$];

   beat_q_t     obs_q;
   int unsigned fe_cnt = 0;
   int unsigned ov_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   uart_rx_axis_master #(
      .CLK_DIV      (CLK_DIV),
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx),
      .M_AXIS_TVALID (tvalid),
      .M_AXIS_TREADY (tready),
      .M_AXIS_TDATA  (tdata),
      .M_AXIS_TKEEP  (tkeep),
      .M_AXIS_TLAST  (tlast),
      .frame_err     (frame_err),
      .overrun_err   (overrun_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (tvalid && tready) obs_q.push_back({tdata, tkeep, tlast});
         if (frame_err)   fe_cnt++;
         if (overrun_err) ov_cnt++;
      end
   end

   // Bytes of a burst form beats of four in arrival order; the final beat carries TLAST.
   function automatic beat_q_t model(input byte_q_t b);
      beat_q_t q;
      int unsigned n = b.size();
      for (int unsigned i = 0; i < n; i += 4) begin
         beat_t e;
         int unsigned k = (n - i < 4) ? n - i : 4;
         e.data = '0;
         for (int unsigned j = 0; j < k; j++) e.data = e.data | (32'(b[i+j]) << (8 * j));
         e.keep = 4'((1 << k) - 1);
         e.last = (i + 4 >= n);
         q.push_back(e);
      end
      return q;
   endfunction

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      step(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         step(CLK_DIV);
      end
      rx = stop;
      step(CLK_DIV);
   endtask

   task automatic wait_beats(input int n, input string name);
      int unsigned budget = 0;
      while (obs_q.size() < n && budget < 400) begin
         step(1);
         budget++;
      end
      checks++;
      if (obs_q.size() < n) begin
         errors++;
         $display("FAIL %s wait: got %0d beats within budget, want %0d", name, obs_q.size(), n);
      end
      step(CLK_DIV * IDLE_TIMEOUT + 8);
   endtask

   task automatic test_reset;
      reset = 1'b1; rx = 1'b1; tready = 1'b1;
      step(3);
      @(negedge clk);
      checks++; if (tvalid !== 1'b0)      begin errors++; $display("FAIL reset tvalid got %b want 0", tvalid); end
      checks++; if (tdata !== 32'h0)      begin errors++; $display("FAIL reset tdata got %h want 0", tdata); end
      checks++; if (tkeep !== 4'h0)       begin errors++; $display("FAIL reset tkeep got %h want 0", tkeep); end
      checks++; if (tlast !== 1'b0)       begin errors++; $display("FAIL reset tlast got %b want 0", tlast); end
      checks++; if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset frame_err got %b want 0", frame_err); end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset overrun_err got %b want 0", overrun_err); end
      step(1);
      reset = 1'b0;
      step(4);
   endtask

   task automatic test_four_bytes;
      byte_q_t b = '{8'h11, 8'h22, 8'h33, 8'h44};
      beat_q_t exp_q = model(b);
      obs_q.delete();
      foreach (b[i]) send_byte(b[i], 1'b1);
      wait_beats(exp_q.size(), "four_bytes");
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL four_bytes count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL four_bytes beat%0d got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
   endtask

   task automatic test_five_bytes;
      byte_q_t b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      beat_q_t exp_q = model(b);
      obs_q.delete();
      foreach (b[i]) send_byte(b[i], 1'b1);
      step(4);
      checks++;
      if (obs_q.size() !== 1) begin
         errors++; $display("FAIL five_bytes early beat count got %0d want 1", obs_q.size());
      end
      wait_beats(exp_q.size(), "five_bytes");
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL five_bytes count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL five_bytes beat%0d got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
   endtask

   task automatic test_frame_err;
      byte_q_t b = '{8'h66};
      beat_q_t exp_q = model(b);
      int unsigned fe0 = fe_cnt;
      obs_q.delete();
      send_byte(8'h55, 1'b0);
      step(CLK_DIV * 30);
      rx = 1'b1;
      step(CLK_DIV * 2);
      checks++;
      if (fe_cnt - fe0 !== 1) begin
         errors++; $display("FAIL frame_err pulses got %0d want 1", fe_cnt - fe0);
      end
      checks++;
      if (obs_q.size() !== 0) begin
         errors++; $display("FAIL frame_err beats got %0d want 0", obs_q.size());
      end
      send_byte(8'h66, 1'b1);
      wait_beats(exp_q.size(), "frame_recover");
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL frame_recover count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL frame_recover beat%0d got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
   endtask

   task automatic test_overrun;
      byte_q_t b;
      beat_q_t exp_q;
      int unsigned ov0 = ov_cnt;
      for (int i = 0; i < 8; i++) b.push_back(8'(i));
      exp_q = model(b);
      obs_q.delete();
      tready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_byte(8'(i), 1'b1);
         if (i >= 5) begin
            checks++;
            if ({tvalid, tdata, tkeep, tlast} !== {1'b1, exp_q[0]}) begin
               errors++;
               $display("FAIL overrun_hold after byte%0d got v=%b %h/%h/%b want v=1 %h/%h/%b", i,
                        tvalid, tdata, tkeep, tlast, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
            end
         end
      end
      step(4);
      checks++;
      if (ov_cnt - ov0 !== 1) begin
         errors++; $display("FAIL overrun pulses got %0d want 1", ov_cnt - ov0);
      end
      tready = 1'b1;
      wait_beats(exp_q.size(), "overrun");
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL overrun count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL overrun beat%0d got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
   endtask

   task automatic test_glitch;
      byte_q_t b = '{8'h3C};
      beat_q_t exp_q = model(b);
      int unsigned fe0 = fe_cnt;
      int unsigned ov0 = ov_cnt;
      obs_q.delete();
      rx = 1'b0;
      step(3);
      rx = 1'b1;
      step(CLK_DIV * 3);
      checks++;
      if ({obs_q.size(), fe_cnt - fe0, ov_cnt - ov0} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL glitch got beats=%0d fe=%0d ov=%0d want 0/0/0", obs_q.size(), fe_cnt - fe0, ov_cnt - ov0);
      end
      send_byte(8'h3C, 1'b1);
      wait_beats(exp_q.size(), "glitch_after");
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL glitch_after count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL glitch_after beat%0d got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
   endtask

   task automatic test_reset_mid;
      byte_q_t b = '{8'h5A};
      beat_q_t exp_q = model(b);
      int unsigned fe0 = fe_cnt;
      int unsigned ov0 = ov_cnt;
      tready = 1'b0;
      send_byte(8'h12, 1'b1);
      step(CLK_DIV * IDLE_TIMEOUT + 8);
      checks++;
      if (tvalid !== 1'b1) begin
         errors++; $display("FAIL reset_mid held beat tvalid got %b want 1", tvalid);
      end
      rx = 1'b0; step(CLK_DIV);
      rx = 1'b1; step(CLK_DIV);
      rx = 1'b0; step(CLK_DIV + 3);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({tvalid, tdata, tkeep, tlast, frame_err, overrun_err} !== 39'h0) begin
         errors++;
         $display("FAIL reset_mid outputs got v=%b %h/%h/%b fe=%b ov=%b want all 0",
                  tvalid, tdata, tkeep, tlast, frame_err, overrun_err);
      end
      rx = 1'b1;
      step(2);
      reset = 1'b0;
      obs_q.delete();
      tready = 1'b1;
      step(CLK_DIV);
      send_byte(8'h5A, 1'b1);
      wait_beats(exp_q.size(), "reset_mid");
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL reset_mid count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL reset_mid beat%0d got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
      checks++;
      if ({fe_cnt - fe0, ov_cnt - ov0} !== {32'd0, 32'd0}) begin
         errors++; $display("FAIL reset_mid error pulses got fe=%0d ov=%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0);
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         byte_q_t b;
         beat_q_t exp_q;
         int unsigned len = $urandom_range(1, 9);
         for (int unsigned i = 0; i < len; i++) b.push_back(8'($urandom));
         exp_q = model(b);
         obs_q.delete();
         foreach (b[i]) begin
            send_byte(b[i], 1'b1);
            if (i + 1 < b.size()) begin
               rx = 1'b1;
               step($urandom_range(0, 16));
            end
         end
         wait_beats(exp_q.size(), "random");
         checks++;
         if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL random burst%0d count got %0d want %0d", r, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL random burst%0d beat%0d got %h/%h/%b want %h/%h/%b", r, i,
                        obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_four_bytes();
      test_five_bytes();
      test_frame_err();
      test_overrun();
      test_glitch();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
